// File: rtl/atm_txn_initiator.sv
// Host-side initiator for the ATM core: accepts one request, presents credentials,
// issues the operation, waits for success or timeout, then returns a one-cycle response.
module atm_txn_initiator #(
  parameter int unsigned AUTH_CYCLES = 2,
  parameter int unsigned RSP_TIMEOUT = 16,
  parameter int unsigned RELEASE_CYC = 2,
  parameter logic [3:0]  IDLE_ACC    = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [3:0]  req_acc,
  input  logic [15:0] req_pin,
  input  logic [15:0] req_new_pin,
  input  logic [31:0] req_amount,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] newPin,
  output logic [31:0] amount,
  input  logic [31:0] balance,
  input  logic        success,
  output logic        rsp_valid,
  output logic        rsp_success,
  output logic        rsp_timeout,
  output logic        rsp_reject,
  output logic [31:0] rsp_balance
);

  // state   | meaning
  // IDLE    | bus parked, ready for a request
  // PRESENT | first cycle loads the bus, then acc/pin held with operation=0
  // OP      | op code driven, waiting for success or timeout
  // RELEASE | bus parked so the ATM falls back to WAITING
  // DONE    | one-cycle response pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_OP,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_BALANCE    = 3'b001;
  localparam logic [2:0] OP_WITHDRAW   = 3'b010;
  localparam logic [2:0] OP_DEPOSIT    = 3'b011;
  localparam logic [2:0] OP_CHANGE_PIN = 3'b100;

  localparam logic [3:0] AUTH_LD = 4'(AUTH_CYCLES);
  localparam logic [3:0] REL_LD  = 4'(RELEASE_CYC - 1);
  localparam logic [7:0] TO_CMP  = 8'(RSP_TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  ph_cnt_q, ph_cnt_d;
  logic [7:0]  timer_q, timer_d;

  logic [2:0]  r_op_q, r_op_d;
  logic [3:0]  r_acc_q, r_acc_d;
  logic [15:0] r_pin_q, r_pin_d;
  logic [15:0] r_new_pin_q, r_new_pin_d;
  logic [31:0] r_amount_q, r_amount_d;

  logic [2:0]  bus_op_q, bus_op_d;
  logic [3:0]  bus_acc_q, bus_acc_d;
  logic [15:0] bus_pin_q, bus_pin_d;
  logic [15:0] bus_new_pin_q, bus_new_pin_d;
  logic [31:0] bus_amount_q, bus_amount_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_success_q, rsp_success_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        rsp_reject_q, rsp_reject_d;
  logic [31:0] rsp_balance_q, rsp_balance_d;

  logic        op_known;
  logic        req_rejected;
  logic        leave_op;

  always_comb begin
    op_known = 1'b0;
    case (req_op)
      OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT, OP_CHANGE_PIN: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
    req_rejected = !op_known ||
                   (((req_op == OP_WITHDRAW) || (req_op == OP_DEPOSIT)) && (req_amount == 32'd0));
  end

  always_comb begin
    state_d       = state_q;
    ph_cnt_d      = ph_cnt_q;
    timer_d       = timer_q;
    r_op_d        = r_op_q;
    r_acc_d       = r_acc_q;
    r_pin_d       = r_pin_q;
    r_new_pin_d   = r_new_pin_q;
    r_amount_d    = r_amount_q;
    bus_op_d      = bus_op_q;
    bus_acc_d     = bus_acc_q;
    bus_pin_d     = bus_pin_q;
    bus_new_pin_d = bus_new_pin_q;
    bus_amount_d  = bus_amount_q;
    rsp_success_d = rsp_success_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_reject_d  = rsp_reject_q;
    rsp_balance_d = rsp_balance_q;
    leave_op      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          r_op_d      = req_op;
          r_acc_d     = req_acc;
          r_pin_d     = req_pin;
          r_new_pin_d = req_new_pin;
          r_amount_d  = req_amount;
          if (req_rejected) begin
            state_d       = S_DONE;
            rsp_success_d = 1'b0;
            rsp_timeout_d = 1'b0;
            rsp_reject_d  = 1'b1;
            rsp_balance_d = 32'd0;
          end else begin
            state_d  = S_PRESENT;
            ph_cnt_d = AUTH_LD;
          end
        end
      end

      S_PRESENT: begin
        bus_acc_d = r_acc_q;
        bus_pin_d = r_pin_q;
        if (ph_cnt_q == 4'd0) begin
          state_d       = S_OP;
          timer_d       = 8'd0;
          bus_op_d      = r_op_q;
          bus_new_pin_d = r_new_pin_q;
          bus_amount_d  = r_amount_q;
        end else begin
          ph_cnt_d = ph_cnt_q - 4'd1;
        end
      end

      S_OP: begin
        timer_d = timer_q + 8'd1;
        // a success flag left over from a previous transaction is ignored at timer 0
        if (success && (timer_q != 8'd0)) begin
          rsp_success_d = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_reject_d  = 1'b0;
          rsp_balance_d = balance;
          leave_op      = 1'b1;
        end else if (timer_q == TO_CMP) begin
          rsp_success_d = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_reject_d  = 1'b0;
          rsp_balance_d = 32'd0;
          leave_op      = 1'b1;
        end
      end

      S_RELEASE: begin
        if (ph_cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          ph_cnt_d = ph_cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (leave_op) begin
      state_d       = S_RELEASE;
      ph_cnt_d      = REL_LD;
      bus_op_d      = 3'd0;
      bus_acc_d     = IDLE_ACC;
      bus_pin_d     = 16'd0;
      bus_new_pin_d = 16'd0;
      bus_amount_d  = 32'd0;
    end

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ph_cnt_q      <= 4'd0;
      timer_q       <= 8'd0;
      r_op_q        <= 3'd0;
      r_acc_q       <= 4'd0;
      r_pin_q       <= 16'd0;
      r_new_pin_q   <= 16'd0;
      r_amount_q    <= 32'd0;
      bus_op_q      <= 3'd0;
      bus_acc_q     <= IDLE_ACC;
      bus_pin_q     <= 16'd0;
      bus_new_pin_q <= 16'd0;
      bus_amount_q  <= 32'd0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_success_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_reject_q  <= 1'b0;
      rsp_balance_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      ph_cnt_q      <= ph_cnt_d;
      timer_q       <= timer_d;
      r_op_q        <= r_op_d;
      r_acc_q       <= r_acc_d;
      r_pin_q       <= r_pin_d;
      r_new_pin_q   <= r_new_pin_d;
      r_amount_q    <= r_amount_d;
      bus_op_q      <= bus_op_d;
      bus_acc_q     <= bus_acc_d;
      bus_pin_q     <= bus_pin_d;
      bus_new_pin_q <= bus_new_pin_d;
      bus_amount_q  <= bus_amount_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_success_q <= rsp_success_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_reject_q  <= rsp_reject_d;
      rsp_balance_q <= rsp_balance_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign operation   = bus_op_q;
  assign acc_num     = bus_acc_q;
  assign pin         = bus_pin_q;
  assign newPin      = bus_new_pin_q;
  assign amount      = bus_amount_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_success = rsp_success_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_reject  = rsp_reject_q;
  assign rsp_balance = rsp_balance_q;

endmodule

// File: tb/tb_atm_txn_initiator.sv
// Randomized bench for atm_txn_initiator: a transaction-timeline model predicts every
// output each cycle; a few directed transactions pin latencies and values to literals.
module tb_atm_txn_initiator;
  localparam int AUTH   = 2;
  localparam int TO     = 16;
  localparam int REL    = 2;
  localparam logic [3:0] PARK_ACC = 4'hF;
  localparam int N_DIR  = 7;
  localparam int N_RAND = 60;
  localparam int TOTAL  = N_DIR + N_RAND;
  localparam int MAXCYC = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_acc;
  logic [15:0] req_pin;
  logic [15:0] req_new_pin;
  logic [31:0] req_amount;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] newPin;
  logic [31:0] amount;
  logic [31:0] balance;
  logic        success;
  logic        rsp_valid;
  logic        rsp_success;
  logic        rsp_timeout;
  logic        rsp_reject;
  logic [31:0] rsp_balance;

  always #5 clk = ~clk;

  atm_txn_initiator dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_acc    (req_acc),
    .req_pin    (req_pin),
    .req_new_pin(req_new_pin),
    .req_amount (req_amount),
    .operation  (operation),
    .acc_num    (acc_num),
    .pin        (pin),
    .newPin     (newPin),
    .amount     (amount),
    .balance    (balance),
    .success    (success),
    .rsp_valid  (rsp_valid),
    .rsp_success(rsp_success),
    .rsp_timeout(rsp_timeout),
    .rsp_reject (rsp_reject),
    .rsp_balance(rsp_balance)
  );

  // directed transactions: balance, withdraw, wrong pin, bad op, zero deposit,
  // change pin with stale success, and one aborted by reset in OP
  int d_op    [N_DIR] = '{1, 2, 1, 0, 3, 4, 1};
  int d_acc   [N_DIR] = '{3, 0, 1, 5, 2, 7, 4};
  int d_pin   [N_DIR] = '{1234, 4321, 1111, 7, 8, 2468, 55};
  int d_npin  [N_DIR] = '{0, 0, 0, 0, 0, 9876, 0};
  int d_amt   [N_DIR] = '{0, 300, 0, 50, 0, 0, 0};
  int d_sd    [N_DIR] = '{1, 3, 99, 0, 0, 0, 99};
  int d_rst   [N_DIR] = '{-1, -1, -1, -1, -1, -1, AUTH + 3};
  int d_lat   [N_DIR] = '{8, 10, 23, 1, 1, 8, -1};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  int cyc = 0;
  int n_acc = 0;
  bit in_txn = 0;
  int a_cyc, off, end_off;
  logic [2:0]  t_op;
  logic [3:0]  t_acc;
  logic [15:0] t_pin, t_npin;
  logic [31:0] t_amt, r_bal;
  bit t_rej, t_succ;
  int t_k, t_d, t_rstoff, t_dir;
  int p_d, p_rstoff, p_dir;
  int tcap;
  bit h_succ = 0, h_to = 0, h_rej = 0;
  logic [31:0] h_bal = 0;
  bit e_ready, e_valid, rdy_now, rst_now;
  logic [2:0]  e_op;
  logic [3:0]  e_acc;
  logic [15:0] e_pin, e_np;
  logic [31:0] e_amt;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_acc = 4'd0; req_pin = 16'd0;
    req_new_pin = 16'd0; req_amount = 32'd0; balance = 32'd0; success = 1'b0;
    p_d = 0; p_rstoff = -1; p_dir = -1;

    while (!(n_acc == TOTAL && !in_txn) && cyc < MAXCYC) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);

      // expected outputs from the current transaction's timeline
      e_ready = !in_txn; e_valid = 0;
      e_op = 3'd0; e_acc = PARK_ACC; e_pin = 16'd0; e_np = 16'd0; e_amt = 32'd0;
      off = cyc - a_cyc;
      end_off = 0;
      if (in_txn) begin
        end_off = t_rej ? 1 : (2 + AUTH + t_k + REL);
        if (!t_rej) begin
          if (off >= 2 && off <= 1 + AUTH) begin
            e_acc = t_acc; e_pin = t_pin;
          end else if (off >= 2 + AUTH && off <= 1 + AUTH + t_k) begin
            e_acc = t_acc; e_pin = t_pin; e_op = t_op; e_np = t_npin; e_amt = t_amt;
          end
        end
        if (off == end_off) e_valid = 1;
      end

      chk("req_ready", req_ready, e_ready, cyc);
      chk("rsp_valid", rsp_valid, e_valid, cyc);
      chk("operation", operation, e_op, cyc);
      chk("acc_num", acc_num, e_acc, cyc);
      chk("pin", pin, e_pin, cyc);
      chk("newPin", newPin, e_np, cyc);
      chk("amount", amount, e_amt, cyc);

      if (cyc == 3) begin
        chk("reset_ready_lit", req_ready, 1, cyc);
        chk("reset_acc_lit", acc_num, 4'hF, cyc);
        chk("reset_rsp_lit", {rsp_success, rsp_timeout, rsp_reject}, 0, cyc);
      end

      if (in_txn && rsp_valid === 1'b1 && t_dir >= 0) begin
        chk("latency_lit", cyc - a_cyc, d_lat[t_dir], cyc);
        if (t_dir == 0) chk("bal4000_lit", rsp_balance, 32'd4000, cyc);
      end

      if (e_valid) begin
        chk("rsp_success", rsp_success, !t_rej && t_succ, cyc);
        chk("rsp_timeout", rsp_timeout, !t_rej && !t_succ, cyc);
        chk("rsp_reject", rsp_reject, t_rej, cyc);
        chk("rsp_balance", rsp_balance, (!t_rej && t_succ) ? r_bal : 32'd0, cyc);
      end else if (!in_txn) begin
        chk("held_success", rsp_success, h_succ, cyc);
        chk("held_timeout", rsp_timeout, h_to, cyc);
        chk("held_reject", rsp_reject, h_rej, cyc);
        chk("held_balance", rsp_balance, h_bal, cyc);
      end

      rdy_now = e_ready;
      if (in_txn && off == end_off) begin
        in_txn = 0;
        h_succ = !t_rej && t_succ;
        h_to   = !t_rej && !t_succ;
        h_rej  = t_rej;
        h_bal  = (!t_rej && t_succ) ? r_bal : 32'd0;
      end

      // reset: initial three cycles, plus any planned mid-transaction abort
      rst_now = 0;
      if (cyc < 3) rst_now = 1;
      else if (in_txn && t_rstoff >= 0 && (cyc - a_cyc) == t_rstoff) rst_now = 1;
      if (rst_now) begin
        in_txn = 0; h_succ = 0; h_to = 0; h_rej = 0; h_bal = 32'd0;
      end
      rst = rst_now;

      // request stimulus
      if (rst_now || n_acc == TOTAL) begin
        req_valid = 1'b0;
      end else if (n_acc < N_DIR) begin
        req_valid   = 1'b1;
        req_op      = 3'(d_op[n_acc]);
        req_acc     = 4'(d_acc[n_acc]);
        req_pin     = 16'(d_pin[n_acc]);
        req_new_pin = 16'(d_npin[n_acc]);
        req_amount  = 32'(d_amt[n_acc]);
        p_d = d_sd[n_acc]; p_rstoff = d_rst[n_acc]; p_dir = n_acc;
      end else begin
        req_valid   = ($urandom_range(0, 3) != 0);
        req_op      = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
        req_acc     = 4'($urandom);
        req_pin     = 16'($urandom);
        req_new_pin = 16'($urandom);
        req_amount  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        p_d = $urandom_range(0, 20);
        p_rstoff = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 8) : -1;
        p_dir = -1;
      end

      if (req_valid && rdy_now && !rst_now) begin
        in_txn = 1; a_cyc = cyc; n_acc++;
        t_op = req_op; t_acc = req_acc; t_pin = req_pin; t_npin = req_new_pin; t_amt = req_amount;
        t_rej = !(req_op >= 3'd1 && req_op <= 3'd4) ||
                ((req_op == 3'd2 || req_op == 3'd3) && req_amount == 32'd0);
        t_d = p_d; t_rstoff = p_rstoff; t_dir = p_dir;
        tcap = (t_d < 1) ? 1 : t_d;
        if (tcap <= TO) begin t_k = tcap + 1; t_succ = 1; end
        else begin t_k = TO + 1; t_succ = 0; end
        r_bal = 32'd0;
      end

      // ATM side: success rises t_d cycles into OP, noise outside the OP window
      off = cyc - a_cyc;
      balance = (in_txn && t_dir == 0) ? 32'd4000 : $urandom;
      if (in_txn && !t_rej && off >= 2 + AUTH && off <= 1 + AUTH + t_k)
        success = ((off - 2 - AUTH) >= t_d);
      else
        success = 1'($urandom);
      if (in_txn && !t_rej && t_succ && off == 1 + AUTH + t_k) r_bal = balance;
    end

    if (cyc >= MAXCYC) begin
      checks++;
      failures++;
      $display("FAIL run_bound cyc=%0d got=unfinished want=finished", cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
